// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, ROM address, IF/ID register, redirects and out-of-range halt.
// Optional performance counters (FetchCnt/StallCnt) are built when IF_STAGE_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] Addr,
  input  logic [31:0] INST,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchImm,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  output logic [31:0] IdInst,
  output logic [31:0] IdPC,
  output logic [31:0] IdPC4,
  output logic        IdValid,
`ifdef IF_STAGE_PERF_CNT_EN
  output logic [31:0] FetchCnt,
  output logic [31:0] StallCnt,
`endif
  output logic        FetchErr
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam int          HI_SHIFT = ROM_AW + 2;
  localparam logic [31:0] PC_RST   = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic        fetch_err_q, fetch_err_d;

  logic        run, oor;
  logic        take_jump, take_branch, take_stall, take_halt, take_fetch;
  logic [31:0] branch_tgt, jump_tgt;

  // Priority decode: jump > branch > stall > out-of-range halt > fetch; nothing acts in HALT.
  always_comb begin
    run         = (state_q == RUN);
    oor         = (pc_q >> HI_SHIFT) != 32'd0;
    take_jump   = run && id_valid_q && Jump;
    take_branch = run && id_valid_q && BranchTaken && !Jump;
    take_stall  = run && !take_jump && !take_branch && Stall;
    take_halt   = run && !take_jump && !take_branch && !Stall && oor;
    take_fetch  = run && !take_jump && !take_branch && !Stall && !oor;
    branch_tgt  = id_pc4_q + {{14{BranchImm[15]}}, BranchImm, 2'b00};
    jump_tgt    = {id_pc4_q[31:28], JumpIndex, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (take_halt) state_d = HALT;
  end

  always_comb begin
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_valid_d  = id_valid_q;
    fetch_err_d = fetch_err_q;
    if (take_jump || take_branch) begin
      pc_d       = take_jump ? jump_tgt : branch_tgt;
      id_inst_d  = 32'd0;
      id_valid_d = 1'b0;
    end else if (take_halt) begin
      id_inst_d   = 32'd0;
      id_valid_d  = 1'b0;
      fetch_err_d = 1'b1;
    end else if (take_fetch) begin
      id_inst_d  = INST;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_q + 32'd4;
      id_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= PC_RST;
      id_inst_q   <= 32'd0;
      id_pc_q     <= 32'd0;
      id_pc4_q    <= 32'd4;
      id_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, take_fetch};
    stall_cnt_d = stall_cnt_q + {31'd0, take_stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchCnt = fetch_cnt_q;
  assign StallCnt = stall_cnt_q;
`endif

  assign Addr     = pc_q;
  assign IdInst   = id_inst_q;
  assign IdPC     = id_pc_q;
  assign IdPC4    = id_pc4_q;
  assign IdValid  = id_valid_q;
  assign FetchErr = fetch_err_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch sequence, stall, branch/jump redirects, halt and async reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr, inst;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [15:0] branch_imm = 16'd0;
  logic [25:0] jump_index = 26'd0;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic        id_valid, fetch_err;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  logic [31:0] rom [256];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign inst = rom[addr[9:2]];

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .Addr(addr), .INST(inst),
    .Stall(stall), .BranchTaken(branch_taken), .BranchImm(branch_imm),
    .Jump(jump), .JumpIndex(jump_index),
    .IdInst(id_inst), .IdPC(id_pc), .IdPC4(id_pc4), .IdValid(id_valid),
`ifdef IF_STAGE_PERF_CNT_EN
    .FetchCnt(fetch_cnt), .StallCnt(stall_cnt),
`endif
    .FetchErr(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | i;
    rom[1] = 32'h0043_0820;
    rom[2] = 32'h0023_2022;

    #12 rst_n = 1'b1;
    check("rst_addr", addr, 32'h0);
    check("rst_idinst", id_inst, 32'h0);
    check("rst_idpc4", id_pc4, 32'h4);
    check("rst_idvalid", {31'd0, id_valid}, 32'h0);
    check("rst_ferr", {31'd0, fetch_err}, 32'h0);

    step();
    check("run_addr4", addr, 32'h4);
    check("run_id0", id_inst, 32'hA000_0000);
    step();
    check("run_addr8", addr, 32'h8);
    check("run_id1", id_inst, 32'h0043_0820);
    check("run_idpc", id_pc, 32'h4);
    check("run_idpc4", id_pc4, 32'h8);
    check("run_valid", {31'd0, id_valid}, 32'h1);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", addr, 32'h8);
      check("stall_id", id_inst, 32'h0043_0820);
      check("stall_idpc", id_pc, 32'h4);
    end
    stall = 1'b0;
    step();
    check("unstall_addr", addr, 32'hC);
    check("unstall_id", id_inst, 32'h0023_2022);
    check("unstall_idpc4", id_pc4, 32'hC);

    // Branch from IdPC=8: target 12 - 8 = 4.
    branch_taken = 1'b1; branch_imm = 16'hFFFE;
    step();
    idle();
    check("br_addr", addr, 32'h4);
    check("br_valid", {31'd0, id_valid}, 32'h0);
    check("br_inst", id_inst, 32'h0);

    // Redirect while IF/ID holds a bubble is ignored.
    jump = 1'b1; jump_index = 26'h3F;
    step();
    idle();
    check("bubble_jump_addr", addr, 32'h8);
    check("bubble_jump_valid", {31'd0, id_valid}, 32'h1);
    step();
    check("refetch_idpc", id_pc, 32'h8);

    branch_taken = 1'b1; stall = 1'b1;
    step();
    idle();
    check("brstall_addr", addr, 32'h4);
    check("brstall_valid", {31'd0, id_valid}, 32'h0);
    check("brstall_inst", id_inst, 32'h0);

    step(); step(); step();
    check("pre_jump_idpc4", id_pc4, 32'h10);
    jump = 1'b1; jump_index = 26'h5; branch_taken = 1'b1; branch_imm = 16'h0040;
    step();
    idle();
    check("jmp_win_addr", addr, 32'h14);
    check("jmp_win_valid", {31'd0, id_valid}, 32'h0);
    check("jmp_win_idpc4", id_pc4, 32'h10);

    step();
    check("fetch14_inst", id_inst, 32'hA000_0005);
    jump = 1'b1; jump_index = 26'h100;
    step();
    idle();
    check("oor_load_addr", addr, 32'h400);
    check("oor_load_ferr", {31'd0, fetch_err}, 32'h0);
    step();
    check("halt_ferr", {31'd0, fetch_err}, 32'h1);
    check("halt_valid", {31'd0, id_valid}, 32'h0);
    check("halt_inst", id_inst, 32'h0);
    check("halt_addr", addr, 32'h400);
    jump = 1'b1; jump_index = 26'h1; stall = 1'b1;
    step();
    check("halt_jump_ign", addr, 32'h400);
    check("halt_ferr_sticky", {31'd0, fetch_err}, 32'h1);
    idle();

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_addr", addr, 32'h0);
    check("async_rst_ferr", {31'd0, fetch_err}, 32'h0);
    check("async_rst_idpc4", id_pc4, 32'h4);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_addr", addr, 32'h4);
    check("post_rst_valid", {31'd0, id_valid}, 32'h1);

`ifdef IF_STAGE_PERF_CNT_EN
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    check("cnt_rst_fetch", fetch_cnt, 32'h0);
    for (int i = 0; i < 5; i++) step();
    stall = 1'b1;
    step(); step();
    idle();
    check("cnt_fetch", fetch_cnt, 32'd5);
    check("cnt_stall", stall_cnt, 32'd2);
    jump = 1'b1; jump_index = 26'h100;
    step();
    idle();
    step();
    check("cnt_halted", {31'd0, fetch_err}, 32'h1);
    stall = 1'b1;
    step(); step();
    idle();
    check("cnt_fetch_frozen", fetch_cnt, 32'd5);
    check("cnt_stall_frozen", stall_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM and feeds the decode stage.
- Holds the program counter and drives the ROM byte address.
- Captures the returned instruction word into an IF/ID pipeline register.
- Applies stall, branch and jump redirects resolved in ID, and halts on a fetch outside ROM range.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset (bits [1:0] ignored, forced 0).
- ROM_AW, 8, ROM word-address width; valid fetch range is 0 to (4<<ROM_AW)-4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Addr  output  32  byte address to instruction ROM (= current PC).
- INST  input  32  combinational instruction word returned by ROM for Addr.
- Stall  input  1  hold PC and IF/ID contents this cycle.
- BranchTaken  input  1  beq in ID resolved taken.
- BranchImm  input  16  beq immediate of the instruction in ID.
- Jump  input  1  j in ID.
- JumpIndex  input  26  j target index of the instruction in ID.
- IdInst  output  32  IF/ID instruction register.
- IdPC  output  32  PC of IdInst.
- IdPC4  output  32  IdPC + 4.
- IdValid  output  1  IdInst is a real instruction, not a bubble.
- FetchErr  output  1  sticky out-of-range fetch flag; block is halted.

Behaviour:
- Reset (asynchronous, active-low):
  - PC = {RESET_PC[31:2], 2'b00}.
  - IdInst = 0, IdPC = 0, IdPC4 = 4, IdValid = 0, FetchErr = 0, state = RUN.
- Addr = PC combinationally. ROM read is combinational; IdInst is valid one cycle after Addr is presented.
- States:
  - RUN: normal fetch.
  - HALT: entered on an out-of-range fetch; left only by reset.
- Out-of-range: PC[31:ROM_AW+2] != 0.
- Redirect targets:
  - Branch target = IdPC4 + {{14{BranchImm[15]}}, BranchImm, 2'b00}, modulo 2^32.
  - Jump target = {IdPC4[31:28], JumpIndex, 2'b00}.
- Per-edge priority in RUN (highest first):
  1. Jump (only when IdValid=1): PC <= jump target; IdInst <= 0; IdValid <= 0; IdPC/IdPC4 hold.
  2. BranchTaken (only when IdValid=1): PC <= branch target; IF/ID flushed as above.
  3. Stall: PC, IdInst, IdPC, IdPC4, IdValid all hold.
  4. Out-of-range PC: IdInst <= 0; IdValid <= 0; FetchErr <= 1; state <= HALT; PC holds.
  5. Otherwise: IdInst <= INST; IdPC <= PC; IdPC4 <= PC+4; IdValid <= 1; PC <= PC+4.
- Redirect overrides Stall: the instruction fetched at the old PC is discarded.
- Jump and BranchTaken asserted together: Jump wins.
- Jump or BranchTaken while IdValid=0: ignored.
- Redirect to an out-of-range target: PC is loaded normally; the halt is detected on the following edge.
- PC increment wraps 32'hFFFFFFFC -> 32'h00000000 (out-of-range unless ROM_AW=30).
- HALT state:
  - PC holds; IdInst = 0; IdValid = 0; FetchErr = 1.
  - Stall, Jump and BranchTaken are ignored.
- Reset mid-operation: all registers return to reset values immediately, independent of clk.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- Defined:
  - Adds outputs FetchCnt[31:0] and StallCnt[31:0], both reset to 0.
  - FetchCnt increments on every edge taking priority-5 (IdValid loaded 1).
  - StallCnt increments on every edge taking priority-3 in RUN.
  - Both counters wrap at 2^32 and freeze in HALT.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then run with ROM word 1 = 32'h00430820 and word 2 = 32'h00232022:
  - Addr = 0, 4, 8 on successive cycles.
  - After the 2nd edge: IdInst = 32'h00430820, IdPC = 4, IdPC4 = 8, IdValid = 1.
- Stall held 3 cycles while PC = 8:
  - Addr stays 8; IdInst/IdPC unchanged.
  - After release, next edge loads the word at 8 and Addr = 12.
- IdPC = 8 (IdPC4 = 12), BranchTaken = 1, BranchImm = 16'hFFFE:
  - Next edge: PC = 4, IdValid = 0, IdInst = 0.
  - Repeat with Stall = 1 simultaneously: same result.
- IdPC4 = 32'h00000010, Jump = 1, JumpIndex = 26'h0000005, BranchTaken = 1:
  - Next edge: PC = 32'h00000014 (jump wins), IdValid = 0.
- Jump to JumpIndex = 26'h0000100 (target 32'h400, ROM_AW = 8):
  - Next edge: PC = 32'h400.
  - Following edge: FetchErr = 1, IdValid = 0, Addr stays 32'h400.
  - Subsequent Jump ignored.
  - rst_n pulsed low mid-cycle: immediate return to Addr = 0, FetchErr = 0.
- With IF_STAGE_PERF_CNT_EN: 5 fetches + 2 stall cycles -> FetchCnt = 5, StallCnt = 2. Counts freeze after HALT.
